// File: rtl/exponent_axil_ctrl_pkg.sv
// Shared constants, state encodings and address decode for the AXI4-Lite power engine slave.
package exponent_axil_ctrl_pkg;

   localparam logic [31:0] OFF_X      = 32'h00;
   localparam logic [31:0] OFF_A      = 32'h04;
   localparam logic [31:0] OFF_CTRL   = 32'h08;
   localparam logic [31:0] OFF_P      = 32'h0C;
   localparam logic [31:0] OFF_STATUS = 32'h10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CTRL_START    = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_CLR_DONE = 2;
   localparam int STAT_DONE     = 0;
   localparam int STAT_BUSY     = 1;
   localparam int STAT_OVF      = 2;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} core_state_e;

   typedef enum logic [2:0] {REG_X, REG_A, REG_CTRL, REG_P, REG_STATUS, REG_NONE} reg_sel_e;

   // Unaligned or out-of-window addresses fall through to REG_NONE.
   function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
      logic [31:0] off;
      off = addr - base;
      case (off)
         OFF_X:      decode_addr = REG_X;
         OFF_A:      decode_addr = REG_A;
         OFF_CTRL:   decode_addr = REG_CTRL;
         OFF_P:      decode_addr = REG_P;
         OFF_STATUS: decode_addr = REG_STATUS;
         default:    decode_addr = REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/exponent_axil_ctrl_core.sv
// Right-to-left square-and-multiply engine: P = X^A mod 2^P_W, one exponent bit per RUN cycle.
module exponent_sqmul_core
   import exponent_axil_ctrl_pkg::*;
#(
   parameter int X_W = 8,
   parameter int A_W = 8,
   parameter int P_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_start,
   input  logic [X_W-1:0] i_X,
   input  logic [A_W-1:0] i_A,
   output logic           o_busy,
   output logic           o_done_pulse,
   output logic           o_ovf,
   output logic [P_W-1:0] o_P
);

   localparam int CW = $clog2(A_W + 1);

   core_state_e      state;
   logic [X_W-1:0]   x_q;
   logic [A_W-1:0]   a_q;
   logic [A_W-1:0]   exp_r;
   logic [P_W-1:0]   base;
   logic [P_W-1:0]   result;
   logic [P_W-1:0]   res_next;
   logic [CW-1:0]    cnt;
   logic [2*P_W-1:0] mul_full;
   logic [2*P_W-1:0] sq_full;
   logic             mul_ovf;
   logic             sq_ovf;
   logic             last;

   always_comb begin
      mul_full = (2*P_W)'(result) * (2*P_W)'(base);
      sq_full  = (2*P_W)'(base) * (2*P_W)'(base);
      res_next = exp_r[0] ? mul_full[P_W-1:0] : result;
      mul_ovf  = exp_r[0] && (mul_full[2*P_W-1:P_W] != '0);
      // A truncated square only matters if a later exponent bit will consume it.
      sq_ovf   = (sq_full[2*P_W-1:P_W] != '0) && ((exp_r >> 1) != '0);
      last     = (cnt == CW'(A_W - 1));
      o_done_pulse = (state == ST_RUN) && last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         x_q    <= '0;
         a_q    <= '0;
         exp_r  <= '0;
         base   <= '0;
         result <= '0;
         cnt    <= '0;
         o_busy <= 1'b0;
         o_ovf  <= 1'b0;
         o_P    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  x_q    <= i_X;
                  a_q    <= i_A;
                  o_busy <= 1'b1;
                  o_ovf  <= 1'b0;
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               base   <= P_W'(x_q);
               result <= P_W'(1);
               exp_r  <= a_q;
               cnt    <= '0;
               state  <= ST_RUN;
            end
            ST_RUN: begin
               result <= res_next;
               base   <= sq_full[P_W-1:0];
               exp_r  <= exp_r >> 1;
               cnt    <= cnt + CW'(1);
               if (mul_ovf || sq_ovf) o_ovf <= 1'b1;
               if (last) begin
                  o_P    <= res_next;
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/exponent_axil_ctrl.sv
// AXI4-Lite slave with register file, status/irq logic and the power engine core.
module exponent_axil_ctrl
   import exponent_axil_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h7C80_0000,
   parameter int          X_W       = 8,
   parameter int          A_W       = 8,
   parameter int          P_W       = 32
) (
   input  logic        S_AXI_ACLK,
   input  logic        S_AXI_ARESET,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   output logic        o_irq
);

   logic           aw_held, w_held;
   logic [31:0]    aw_addr_q, w_data_q;
   logic [3:0]     w_strb_q;
   logic [X_W-1:0] x_q;
   logic [A_W-1:0] a_q;
   logic           irq_en, done;
   logic           busy, done_pulse, ovf;
   logic [P_W-1:0] p_val;

   logic           aw_hs, w_hs, ar_hs, wr_fire;
   logic           aw_held_n, w_held_n, bvalid_n, rvalid_n;
   reg_sel_e       wr_sel, rd_sel;
   logic           ctrl_act, start_busy_err, wr_err, start, clr_done;
   logic [31:0]    rd_val;
   logic [1:0]     rd_resp;
   logic           unused_wdata;

   assign unused_wdata = ^w_data_q;
   assign o_irq = done & irq_en;

   always_comb begin
      aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
      w_hs    = S_AXI_WVALID & S_AXI_WREADY;
      ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
      wr_fire = aw_held & w_held & ~S_AXI_BVALID;

      aw_held_n = wr_fire ? 1'b0 : (aw_held | aw_hs);
      w_held_n  = wr_fire ? 1'b0 : (w_held | w_hs);
      bvalid_n  = wr_fire | (S_AXI_BVALID & ~S_AXI_BREADY);
      rvalid_n  = ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);

      wr_sel         = decode_addr(aw_addr_q, BASE_ADDR);
      rd_sel         = decode_addr(S_AXI_ARADDR, BASE_ADDR);
      ctrl_act       = wr_fire && (wr_sel == REG_CTRL) && w_strb_q[0];
      start_busy_err = ctrl_act && w_data_q[CTRL_START] && busy;
      wr_err         = (wr_sel == REG_NONE) || (wr_sel == REG_P) || (wr_sel == REG_STATUS) ||
                       start_busy_err;
      start          = ctrl_act && w_data_q[CTRL_START] && !busy;
      clr_done       = ctrl_act && !start_busy_err && w_data_q[CTRL_CLR_DONE];

      rd_val  = '0;
      rd_resp = RESP_OKAY;
      case (rd_sel)
         REG_X:      rd_val = 32'(x_q);
         REG_A:      rd_val = 32'(a_q);
         REG_CTRL:   rd_val[CTRL_IRQ_EN] = irq_en;
         REG_P:      rd_val = 32'(p_val);
         REG_STATUS: begin
            rd_val[STAT_DONE] = done;
            rd_val[STAT_BUSY] = busy;
            rd_val[STAT_OVF]  = ovf;
         end
         default:    rd_resp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OKAY;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_addr_q     <= '0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         x_q           <= '0;
         a_q           <= '0;
         irq_en        <= 1'b0;
         done          <= 1'b0;
      end else begin
         aw_held       <= aw_held_n;
         w_held        <= w_held_n;
         S_AXI_BVALID  <= bvalid_n;
         S_AXI_RVALID  <= rvalid_n;
         S_AXI_AWREADY <= ~aw_held_n & ~bvalid_n;
         S_AXI_WREADY  <= ~w_held_n & ~bvalid_n;
         S_AXI_ARREADY <= ~rvalid_n;

         if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
         if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end

         if (wr_fire) begin
            S_AXI_BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (!wr_err) begin
               case (wr_sel)
                  REG_X:
                     for (int unsigned i = 0; i < X_W; i++)
                        if (w_strb_q[i/8]) x_q[i] <= w_data_q[i];
                  REG_A:
                     for (int unsigned i = 0; i < A_W; i++)
                        if (w_strb_q[i/8]) a_q[i] <= w_data_q[i];
                  REG_CTRL:
                     if (w_strb_q[0]) irq_en <= w_data_q[CTRL_IRQ_EN];
                  default: ;
               endcase
            end
         end

         // start beats a clr_done in the same write; a core completion beats a clr_done.
         if (start)           done <= 1'b0;
         else if (done_pulse) done <= 1'b1;
         else if (clr_done)   done <= 1'b0;

         if (ar_hs) begin
            S_AXI_RDATA <= rd_val;
            S_AXI_RRESP <= rd_resp;
         end
      end
   end

   exponent_sqmul_core #(
      .X_W(X_W),
      .A_W(A_W),
      .P_W(P_W)
   ) u_core (
      .clk          (S_AXI_ACLK),
      .rst          (S_AXI_ARESET),
      .i_start      (start),
      .i_X          (x_q),
      .i_A          (a_q),
      .o_busy       (busy),
      .o_done_pulse (done_pulse),
      .o_ovf        (ovf),
      .o_P          (p_val)
   );

endmodule

// File: tb/tb_exponent_axil_ctrl.sv
// Directed self-checking bench for exponent_axil_ctrl with default parameters.
module tb_exponent_axil_ctrl;

   localparam logic [31:0] BASE = 32'h7C80_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, irq;
   logic [1:0]  bresp, rresp;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exponent_axil_ctrl dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .o_irq         (irq)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output int unsigned commit);
      int  n;
      logic aw_go, w_go;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 50) begin
         aw_go = awready; w_go = wready;
         @(posedge clk); #1;
         if (aw_go) awvalid = 1'b0;
         if (w_go)  wvalid  = 1'b0;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bvalid) check_val("wr_bvalid_timeout", 32'(bvalid), 32'd1);
      commit = cyc - 1;
      resp = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int  n;
      logic go;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (arvalid && n < 50) begin
         go = arready;
         @(posedge clk); #1;
         if (go) arvalid = 1'b0;
         n++;
      end
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rvalid) check_val("rd_rvalid_timeout", 32'(rvalid), 32'd1);
      data = rdata; resp = rresp;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic wait_done(output logic [31:0] st);
      logic [1:0] r;
      int n;
      n = 0;
      axi_read(BASE + 32'h10, st, r);
      while (!st[0] && n < 40) begin
         axi_read(BASE + 32'h10, st, r);
         n++;
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int unsigned cm, rise;
      int          held, n;
      logic        go;

      rst = 1'b1;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_awready", 32'(awready), 0);
      check_val("rst_wready",  32'(wready), 0);
      check_val("rst_arready", 32'(arready), 0);
      check_val("rst_bvalid",  32'(bvalid), 0);
      check_val("rst_rvalid",  32'(rvalid), 0);
      check_val("rst_rdata",   rdata, 0);
      check_val("rst_irq",     32'(irq), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      axi_read(BASE + 32'h00, d, r); check_val("rst_x", d, 0); check_val("rst_x_resp", 32'(r), 0);
      axi_read(BASE + 32'h0C, d, r); check_val("rst_p", d, 0);
      axi_read(BASE + 32'h10, d, r); check_val("rst_status", d, 0);

      // 3^4
      axi_write(BASE + 32'h00, 32'd3, 4'hF, r, cm);
      axi_write(BASE + 32'h04, 32'd4, 4'hF, r, cm);
      axi_write(BASE + 32'h08, 32'd1, 4'hF, r, cm); check_val("start_resp", 32'(r), 0);
      wait_done(d); check_val("j1_status", d, 32'h1);
      axi_read(BASE + 32'h0C, d, r); check_val("j1_p_81", d, 32'd81);

      // 2^40 overflows to 0, then 0^0 = 1 clears ovf
      axi_write(BASE + 32'h00, 32'd2, 4'hF, r, cm);
      axi_write(BASE + 32'h04, 32'd40, 4'hF, r, cm);
      axi_write(BASE + 32'h08, 32'd1, 4'hF, r, cm);
      wait_done(d); check_val("j2_status_ovf", d, 32'h5);
      axi_read(BASE + 32'h0C, d, r); check_val("j2_p_0", d, 32'd0);
      axi_write(BASE + 32'h00, 32'd0, 4'hF, r, cm);
      axi_write(BASE + 32'h04, 32'd0, 4'hF, r, cm);
      axi_write(BASE + 32'h08, 32'd1, 4'hF, r, cm);
      wait_done(d); check_val("j3_status", d, 32'h1);
      axi_read(BASE + 32'h0C, d, r); check_val("j3_p_1", d, 32'd1);

      // 5^3 with a rejected restart and an X write while running
      axi_write(BASE + 32'h00, 32'd5, 4'hF, r, cm);
      axi_write(BASE + 32'h04, 32'd3, 4'hF, r, cm);
      axi_write(BASE + 32'h08, 32'd1, 4'hF, r, cm);
      axi_write(BASE + 32'h08, 32'd1, 4'hF, r, cm); check_val("busy_start_slverr", 32'(r), 32'h2);
      axi_write(BASE + 32'h00, 32'd7, 4'hF, r, cm); check_val("x_mid_job_resp", 32'(r), 0);
      axi_read(BASE + 32'h10, d, r); check_val("j4_busy", d, 32'h2);
      wait_done(d); check_val("j4_status", d, 32'h1);
      axi_read(BASE + 32'h0C, d, r); check_val("j4_p_125", d, 32'd125);
      axi_read(BASE + 32'h00, d, r); check_val("j4_x_7", d, 32'd7);

      // Unmapped / read-only / unaligned / masked CTRL
      axi_read(BASE + 32'h14, d, r); check_val("rd_unmapped_resp", 32'(r), 32'h2); check_val("rd_unmapped_data", d, 0);
      axi_write(BASE + 32'h0C, 32'hDEAD, 4'hF, r, cm); check_val("wr_p_slverr", 32'(r), 32'h2);
      axi_read(BASE + 32'h0C, d, r); check_val("p_unchanged", d, 32'd125);
      axi_read(BASE + 32'h02, d, r); check_val("rd_unaligned_resp", 32'(r), 32'h2);
      axi_write(BASE + 32'h08, 32'd1, 4'h0, r, cm); check_val("ctrl_nostrb_resp", 32'(r), 0);
      axi_read(BASE + 32'h10, d, r); check_val("ctrl_nostrb_idle", d, 32'h1);

      // Byte strobes
      axi_write(BASE + 32'h00, 32'h11, 4'hF, r, cm);
      axi_write(BASE + 32'h00, 32'hFF, 4'h0, r, cm);
      axi_read(BASE + 32'h00, d, r); check_val("x_strb0", d, 32'h11);
      axi_write(BASE + 32'h00, 32'hAA, 4'hE, r, cm);
      axi_read(BASE + 32'h00, d, r); check_val("x_strb_e", d, 32'h11);
      axi_write(BASE + 32'h00, 32'h55, 4'h1, r, cm);
      axi_read(BASE + 32'h00, d, r); check_val("x_strb_1", d, 32'h55);

      // W three cycles ahead of AW, BREADY held low
      awaddr = BASE + 32'h04; wdata = 32'd9; wstrb = 4'hF; bready = 1'b0;
      wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         go = wready;
         @(posedge clk); #1;
         if (go) wvalid = 1'b0;
      end
      check_val("w_early_accepted", 32'(wvalid), 0);
      wvalid = 1'b0;
      awvalid = 1'b1; n = 0;
      while (awvalid && n < 50) begin
         go = awready;
         @(posedge clk); #1;
         if (go) awvalid = 1'b0;
         n++;
      end
      awvalid = 1'b0; n = 0;
      while (!bvalid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      held = 0;
      for (int i = 0; i < 5; i++) begin
         if (bvalid) held++;
         @(posedge clk); #1;
      end
      check_val("bvalid_held_5", 32'(held), 32'd5);
      check_val("awready_during_b", 32'(awready), 0);
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      held = 0;
      for (int i = 0; i < 4; i++) begin
         if (bvalid) held++;
         @(posedge clk); #1;
      end
      check_val("single_commit", 32'(held), 0);
      axi_read(BASE + 32'h04, d, r); check_val("a_9", d, 32'd9);

      // Interrupt with exact completion latency
      axi_write(BASE + 32'h08, 32'd6, 4'hF, r, cm);
      check_val("irq_after_clr", 32'(irq), 0);
      axi_read(BASE + 32'h08, d, r); check_val("ctrl_rd", d, 32'h2);
      axi_write(BASE + 32'h00, 32'd3, 4'hF, r, cm);
      axi_write(BASE + 32'h04, 32'd4, 4'hF, r, cm);
      axi_write(BASE + 32'h08, 32'd3, 4'hF, r, cm);
      check_val("irq_low_running", 32'(irq), 0);
      n = 0;
      while (!irq && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      rise = cyc;
      check_val("irq_rises", 32'(irq), 32'd1);
      check_val("done_latency_10", rise - cm, 32'd10);
      axi_read(BASE + 32'h0C, d, r); check_val("j5_p_81", d, 32'd81);
      axi_write(BASE + 32'h08, 32'd6, 4'hF, r, cm);
      check_val("irq_cleared", 32'(irq), 0);
      axi_read(BASE + 32'h10, d, r); check_val("done_cleared", d, 32'h0);

      // Reset in the middle of RUN with a read in flight
      axi_write(BASE + 32'h08, 32'd1, 4'hF, r, cm);
      repeat (2) @(posedge clk);
      #1;
      araddr = BASE + 32'h0C; arvalid = 1'b1; rready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("midrst_rvalid", 32'(rvalid), 0);
      check_val("midrst_bvalid", 32'(bvalid), 0);
      check_val("midrst_arready", 32'(arready), 0);
      check_val("midrst_irq", 32'(irq), 0);
      rst = 1'b0; arvalid = 1'b0;
      @(posedge clk); #1;
      axi_read(BASE + 32'h10, d, r); check_val("midrst_status", d, 0);
      axi_read(BASE + 32'h0C, d, r); check_val("midrst_p", d, 0);
      axi_read(BASE + 32'h00, d, r); check_val("midrst_x", d, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
